// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue and its bench.
package fetch_pkg;

    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_DEPTH      = 4;
    localparam int PTR_W            = $clog2(FETCH_DEPTH) + 1;

    localparam logic [FETCH_DATA_WIDTH-1:0] FETCH_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_DATA_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_ram.sv
// Entry storage: PC written at request time, instruction at response time,
// combinational read of the head entry. The array is deliberately not reset.
module fetch_entry_ram
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int DEPTH      = FETCH_DEPTH,
    parameter int IDX_W      = $clog2(FETCH_DEPTH)
) (
    input  logic                  clk,
    input  logic                  pc_we_i,
    input  logic [IDX_W-1:0]      pc_idx_i,
    input  logic [DATA_WIDTH-1:0] pc_wdata_i,
    input  logic                  instr_we_i,
    input  logic [IDX_W-1:0]      instr_idx_i,
    input  logic [DATA_WIDTH-1:0] instr_wdata_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_pc_o,
    output logic [DATA_WIDTH-1:0] rd_instr_o
);

    logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

    // Independent write ports for the PC and instruction halves of each entry
    always_ff @(posedge clk) begin
        if (pc_we_i) begin
            pc_mem_q[pc_idx_i] <= pc_wdata_i;
        end
        if (instr_we_i) begin
            instr_mem_q[instr_idx_i] <= instr_wdata_i;
        end
    end

    assign rd_pc_o    = pc_mem_q[rd_idx_i];
    assign rd_instr_o = instr_mem_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue_checker.sv
// Protocol checks for the fetch queue: memory responses need a request behind them.
module fetch_queue_checker #(
    parameter int PW = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          resp_valid_i,
    input logic [PW-1:0] live_inflight_i,
    input logic [PW-1:0] drop_cnt_i
);

    a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
        resp_valid_i |-> ((live_inflight_i != '0) || (drop_cnt_i != '0)))
        else $error("fetch_queue: response with no request outstanding");

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues PCs to instruction memory, collects in-order
// responses and hands {pc, instr} pairs to decode; redirect orphans in-flight fetches.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int DEPTH      = FETCH_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic                  pc_advance,
    input  logic                  redirect,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_pc,
    output logic [DATA_WIDTH-1:0] dec_instr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = IDX_W + 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [PW-1:0]         alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d, drop_q, drop_d;
    logic [PW-1:0]         occupancy_s, live_s;
    logic [PW:0]           committed_s;
    logic                  fill_we_s, pop_s;
    logic [DATA_WIDTH-1:0] rd_pc_s, rd_instr_s, hold_pc_q, hold_instr_q;

    assign occupancy_s = alloc_q - rd_q;
    assign live_s      = alloc_q - fill_q;
    // Orphaned requests still hold a slot until their response drains.
    assign committed_s = {1'b0, occupancy_s} + {1'b0, drop_q};

    assign imem_req_valid = !rst && !redirect && (committed_s < DEPTH_C);
    assign imem_req_addr  = pc_in;
    assign pc_advance     = imem_req_valid && imem_req_ready;
    assign dec_valid      = !rst && !redirect && (rd_q != fill_q);
    assign pop_s          = dec_valid && dec_ready;
    assign dec_pc         = dec_valid ? rd_pc_s    : hold_pc_q;
    assign dec_instr      = dec_valid ? rd_instr_s : hold_instr_q;

    // Next-state for pointers and the orphan counter
    always_comb begin
        alloc_d   = alloc_q;
        fill_d    = fill_q;
        rd_d      = rd_q;
        drop_d    = drop_q;
        fill_we_s = 1'b0;
        if (redirect) begin
            fill_d = alloc_q;
            rd_d   = alloc_q;
            drop_d = drop_q + live_s - PW'(imem_resp_valid);
        end else begin
            if (pc_advance) begin
                alloc_d = alloc_q + PW'(1);
            end else begin
                alloc_d = alloc_q;
            end
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - PW'(1);
            end else if (imem_resp_valid) begin
                fill_we_s = 1'b1;
                fill_d    = fill_q + PW'(1);
            end else begin
                fill_d = fill_q;
            end
            if (pop_s) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
        end
    end

    // Pointer and counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_q <= '0;
            fill_q  <= '0;
            rd_q    <= '0;
            drop_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
        end
    end

    // Last value shown to decode, held while the queue head is not valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else if (dec_valid) begin
            hold_pc_q    <= rd_pc_s;
            hold_instr_q <= rd_instr_s;
        end else begin
            hold_pc_q    <= hold_pc_q;
            hold_instr_q <= hold_instr_q;
        end
    end

    fetch_entry_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk           (clk),
        .pc_we_i       (pc_advance),
        .pc_idx_i      (alloc_q[IDX_W-1:0]),
        .pc_wdata_i    (pc_in),
        .instr_we_i    (fill_we_s),
        .instr_idx_i   (fill_q[IDX_W-1:0]),
        .instr_wdata_i (imem_resp_data),
        .rd_idx_i      (rd_q[IDX_W-1:0]),
        .rd_pc_o       (rd_pc_s),
        .rd_instr_o    (rd_instr_s)
    );

    fetch_queue_checker #(
        .PW (PW)
    ) u_chk (
        .clk             (clk),
        .rst             (rst),
        .resp_valid_i    (imem_resp_valid),
        .live_inflight_i (live_s),
        .drop_cnt_i      (drop_q)
    );

endmodule
